// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one sequential Booth multiplier core
// among NREQ requesters; owns every core control input.
module mul_share_arbiter #(
   parameter int unsigned N         = 32,
   parameter int unsigned NREQ      = 4,
   parameter int unsigned INIT_WAIT = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ*N-1:0]    req_a,
   input  logic [NREQ*N-1:0]    req_b,
   output logic [NREQ-1:0]      req_ready,
   output logic [NREQ-1:0]      rsp_valid,
   input  logic [NREQ-1:0]      rsp_ready,
   output logic [2*N-1:0]       rsp_c,
   output logic                 busy,
   output logic                 init_err,
   output logic                 mul_load,
   output logic                 mul_recieved,
   output logic [N-1:0]         mul_a,
   output logic [N-1:0]         mul_b,
   input  logic                 mul_done,
   input  logic                 mul_init,
   input  logic [2*N-1:0]       mul_c
);

   localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned CW = $clog2(INIT_WAIT + 1);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_INIT,
      WAIT_DONE,
      ACK,
      RESP
   } state_t;

   state_t          state;
   logic [IW-1:0]   last;
   logic [IW-1:0]   gnt;
   logic [CW-1:0]   wait_cnt;
   logic [IW-1:0]   pick;
   logic            pick_ok;
   logic            accept;

   // First valid requester searching upward from last+1 with wrap-around.
   always_comb begin
      int unsigned idx;
      logic [IW-1:0] sel;
      pick_ok = 1'b0;
      pick    = '0;
      idx     = 0;
      sel     = '0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         idx = 32'(last) + k;
         if (idx >= NREQ)
            idx = idx - NREQ;
         sel = IW'(idx);
         if (!pick_ok && req_valid[sel]) begin
            pick_ok = 1'b1;
            pick    = sel;
         end
      end
   end

   // IDLE holds off while the core's done bit drains from the previous operation.
   assign accept    = (state == IDLE) && !mul_done && pick_ok;
   assign req_ready = (accept && rst_n) ? (NREQ'(1) << pick) : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         last         <= IW'(NREQ - 1);
         gnt          <= '0;
         wait_cnt     <= '0;
         mul_a        <= '0;
         mul_b        <= '0;
         rsp_c        <= '0;
         rsp_valid    <= '0;
         busy         <= 1'b0;
         init_err     <= 1'b0;
         mul_load     <= 1'b0;
         mul_recieved <= 1'b0;
      end else begin
         mul_load     <= 1'b0;
         mul_recieved <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  mul_a    <= req_a[pick*N +: N];
                  mul_b    <= req_b[pick*N +: N];
                  gnt      <= pick;
                  last     <= pick;
                  busy     <= 1'b1;
                  mul_load <= 1'b1;
                  state    <= ISSUE;
               end
            end
            ISSUE: begin
               wait_cnt <= '0;
               state    <= WAIT_INIT;
            end
            WAIT_INIT: begin
               if (mul_init) begin
                  state <= WAIT_DONE;
               end else if (wait_cnt == CW'(INIT_WAIT - 1)) begin
                  init_err <= 1'b1;
                  state    <= WAIT_DONE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            WAIT_DONE: begin
               if (mul_done) begin
                  rsp_c        <= mul_c;
                  mul_recieved <= 1'b1;
                  state        <= ACK;
               end
            end
            ACK: begin
               rsp_valid <= NREQ'(1) << gnt;
               state     <= RESP;
            end
            RESP: begin
               if (rsp_ready[gnt]) begin
                  rsp_valid <= '0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/mul_share_arbiter.md
# mul_share_arbiter

Round-robin arbiter and sequencer that shares one sequential Booth multiplier core among NREQ requesters. It accepts operand pairs on per-requester valid/ready ports, drives the core's load/recieved handshake, captures the 2N-bit signed product and returns it to the granted requester on a response handshake. It sits between the requesting datapath units and the single multiplier instance, and owns every core control input.

## Interface
- N, 32, operand width; the product is 2N bits.
- NREQ, 4, number of requesters (2..8).
- INIT_WAIT, 4, maximum cycles from mul_load to mul_init before init_err is set.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low. It is shared with the multiplier core.
- req_valid  in  NREQ  per-requester operand valid.
- req_a, req_b  in  NREQ*N  packed operands; slice i is [i*N +: N].
- req_ready  out  NREQ  one-hot accept pulse.
- rsp_valid  out  NREQ  one-hot; the result is valid for the granted requester.
- rsp_ready  in  NREQ  per-requester result accept.
- rsp_c  out  2N  captured product.
- busy  out  1  high from accept until the return to IDLE.
- init_err  out  1  sticky; cleared only by reset.
- mul_load, mul_recieved  out  1  core controls.
- mul_a, mul_b  out  N  core operands.
- mul_done, mul_init  in  1  core status.
- mul_c  in  2N  core product.

## Operation
- Reset values:
  - Outputs are 0: req_ready, rsp_valid, rsp_c, busy, init_err, mul_load, mul_recieved, mul_a, mul_b.
  - State is IDLE.
  - Round-robin pointer last = NREQ-1, so requester 0 has first priority.
- **IDLE**
  - Stays in IDLE while mul_done=1. This drains the done bit, which is registered in the core and is still high for one cycle after recieved.
  - Otherwise, if any req_valid is high, it grants the first set bit searching from last+1 with wrap-around.
  - In the same cycle it drives req_ready[g]=1, registers req_a[g]/req_b[g] into mul_a/mul_b, stores g and sets last=g.
  - Next state is ISSUE.
- **ISSUE**
  - mul_load=1 for exactly one cycle.
  - The init-wait counter is cleared.
  - Next state is WAIT_INIT.
- **WAIT_INIT**
  - On mul_init=1, go to WAIT_DONE.
  - If the counter reaches INIT_WAIT without mul_init, set init_err=1 and go to WAIT_DONE anyway.
- **WAIT_DONE**
  - On mul_done=1, latch rsp_c=mul_c and go to ACK.
- **ACK**
  - mul_recieved=1 for exactly one cycle.
  - Next state is RESP.
- **RESP**
  - rsp_valid[g]=1 and rsp_c is held.
  - On rsp_ready[g]=1, rsp_valid drops and the next state is IDLE.
  - rsp_ready bits of other requesters are ignored.
- Operand stability:
  - mul_a/mul_b change only on an IDLE accept.
  - They are therefore stable through the core's INIT capture.
- Arithmetic:
  - The arbiter is pass-through. rsp_c is the core's 2N-bit two's-complement product, unmodified.
- Simultaneous events:
  - A request arriving in the same cycle as a response accept is not granted until IDLE.
  - A requester whose req_valid drops before grant is simply skipped.
  - At most one operation is in flight.
- Reset mid-operation:
  - Any state returns to IDLE immediately.
  - The pending operation and its response are discarded.
  - The core resets through the same rst_n.

## Timing
- Accept cycle T: req_ready pulses, and mul_a/mul_b are valid from T+1.
- mul_load is high at T+1. The core shows mul_init=1 at T+3.
- mul_done arrives after a number of cycles set by the core, which depends on the data. The arbiter imposes no bound.
- Capture happens in the cycle mul_done=1 is first seen (W), with mul_recieved high at W+1.
- rsp_valid is high from W+2.
- After the rsp_ready accept, the next grant happens no earlier than the first IDLE cycle with mul_done=0. The arbiter therefore never issues mul_load while the core is still in DONE.
- Back-to-back throughput: one operation per (core latency + 4 + response wait) cycles.

## Test plan
- Single request: requester 1 sends A=7, B=-3.
  - Expect exactly one req_ready[1] pulse and one mul_load pulse.
  - Expect rsp_valid[1] with rsp_c=-21 (64'hFFFF_FFFF_FFFF_FFEB).
  - Expect one mul_recieved pulse, then busy=0.
- All four requesters valid continuously with distinct operands:
  - Grants are in order 0,1,2,3,0.
  - Each response carries the correct product.
  - No mul_load occurs while mul_done=1.
- Response backpressure:
  - Hold rsp_ready[2]=0 for 20 cycles.
  - rsp_valid[2] and rsp_c stay stable.
  - No new grant occurs.
  - The accept releases it.
- Corner operands:
  - A=-2^31, B=-1 gives 2^31.
  - A=0, B=-1 gives 0.
  - A=-1, B=-1 gives 1.
- Stub core that never raises mul_init:
  - init_err=1 after INIT_WAIT cycles and stays set.
  - The FSM still waits for done.
- Reset mid-operation:
  - Assert rst_n=0 during WAIT_DONE.
  - All outputs go to 0 asynchronously.
  - After release, requester 0 wins first.
